// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa cell, one operand bit per cycle, N+1 bit result.
// valid/ready on both sides; one operation in flight at a time.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [N-1:0]  res_next;
    logic          carry;
    logic [CW-1:0] count;
    logic          s;
    logic          co;

    fa the_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // Result bits enter at the MSB so the LSB lands at bit 0 after N shifts.
    generate
        if (N == 1) begin : g_one
            assign res_next = s;
        end else begin : g_wide
            assign res_next = {s, res[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            sum   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= ci;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res   <= res_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= co;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        sum   <= {co, res_next};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !clear;
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed N=8 scenarios plus
// random traffic on N=8, N=1 and N=16 instances sharing clock and clear.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;
    logic        rv  [3];
    logic        ror [3];
    logic        rci [3];
    logic [15:0] ra  [3];
    logic [15:0] rb  [3];
    logic [2:0]  irdy;
    logic [2:0]  ovld;
    logic [8:0]  s0;
    logic [1:0]  s1;
    logic [16:0] s2;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    serial_adder #(.N(8)) dut8 (
        .clock(clk), .clear(clear),
        .in_valid(rv[0]), .in_ready(irdy[0]),
        .a(ra[0][7:0]), .b(rb[0][7:0]), .ci(rci[0]),
        .out_valid(ovld[0]), .out_ready(ror[0]), .sum(s0)
    );

    serial_adder #(.N(1)) dut1 (
        .clock(clk), .clear(clear),
        .in_valid(rv[1]), .in_ready(irdy[1]),
        .a(ra[1][0:0]), .b(rb[1][0:0]), .ci(rci[1]),
        .out_valid(ovld[1]), .out_ready(ror[1]), .sum(s1)
    );

    serial_adder #(.N(16)) dut16 (
        .clock(clk), .clear(clear),
        .in_valid(rv[2]), .in_ready(irdy[2]),
        .a(ra[2]), .b(rb[2]), .ci(rci[2]),
        .out_valid(ovld[2]), .out_ready(ror[2]), .sum(s2)
    );

    function automatic int wid(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic [16:0] getsum(input int k);
        case (k)
            0:       return {8'd0, s0};
            1:       return {15'd0, s1};
            default: return s2;
        endcase
    endfunction

    // Drives one handshake on the N=8 instance; returns sum and cycles to out_valid.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic c, output logic [8:0] s,
                          output int lat);
        int n;
        n = 0;
        ror[0] = 1'b1;
        while (!irdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        ra[0] = {8'd0, x};
        rb[0] = {8'd0, y};
        rci[0] = c;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        lat = 1;
        while (!ovld[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        s = s0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        rv[0] = 1'b1;
        ra[0] = 16'h00FF;
        rb[0] = 16'h00FF;
        repeat (2) @(negedge clk);
        compared++;
        if (irdy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b want 0", irdy[0]);
        end
        compared++;
        if (ovld !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b want 000", ovld);
        end
        compared++;
        if (s0 !== 9'h000) begin
            mismatched++;
            $display("FAIL reset_sum: got %h want 000", s0);
        end
        clear = 1'b0;
        rv[0] = 1'b0;
        @(negedge clk);
        compared++;
        if (irdy !== 3'b111) begin
            mismatched++;
            $display("FAIL post_reset_in_ready: got %b want 111", irdy);
        end
        compared++;
        if (ovld[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_out_valid: got %b want 0", ovld[0]);
        end
    endtask

    task automatic test_basic();
        logic [8:0] s;
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, s, lat);
        compared++;
        if (s !== 9'h100) begin
            mismatched++;
            $display("FAIL basic_sum: got %h want 100", s);
        end
        compared++;
        if (lat !== 9) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d want 9", lat);
        end
    endtask

    task automatic test_extremes();
        logic [8:0] s;
        int lat;
        run_op(8'hFF, 8'hFF, 1'b1, s, lat);
        compared++;
        if (s !== 9'h1FF) begin
            mismatched++;
            $display("FAIL max_sum: got %h want 1ff", s);
        end
        run_op(8'h00, 8'h00, 1'b0, s, lat);
        compared++;
        if (s !== 9'h000) begin
            mismatched++;
            $display("FAIL zero_sum: got %h want 000", s);
        end
        compared++;
        if (lat !== 9) begin
            mismatched++;
            $display("FAIL zero_latency: got %0d want 9", lat);
        end
    endtask

    task automatic test_backpressure();
        int n;
        ror[0] = 1'b0;
        ra[0] = 16'h005A;
        rb[0] = 16'h003C;
        rci[0] = 1'b0;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        n = 0;
        while (!ovld[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            ra[0] = 16'h00FF;
            rb[0] = 16'h00FF;
            rci[0] = 1'b1;
            rv[0] = 1'b1;
            compared++;
            if (s0 !== 9'h096) begin
                mismatched++;
                $display("FAIL bp_sum[%0d]: got %h want 096", i, s0);
            end
            compared++;
            if (ovld[0] !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_out_valid[%0d]: got %b want 1", i, ovld[0]);
            end
            compared++;
            if (irdy[0] !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_in_ready[%0d]: got %b want 0", i, irdy[0]);
            end
            @(negedge clk);
        end
        rv[0] = 1'b0;
        ror[0] = 1'b1;
        @(negedge clk);
        compared++;
        if ({irdy[0], ovld[0]} !== 2'b10) begin
            mismatched++;
            $display("FAIL bp_release: got rdy/vld %b want 10", {irdy[0], ovld[0]});
        end
        @(negedge clk);
        compared++;
        if (irdy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_no_accept: got in_ready %b want 1", irdy[0]);
        end
    endtask

    task automatic test_clear_busy();
        logic [8:0] s;
        int lat;
        int bad;
        ror[0] = 1'b1;
        ra[0] = 16'h0012;
        rb[0] = 16'h0034;
        rci[0] = 1'b1;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        compared++;
        if ({irdy[0], ovld[0]} !== 2'b10) begin
            mismatched++;
            $display("FAIL clear_busy_idle: got rdy/vld %b want 10", {irdy[0], ovld[0]});
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ovld[0] !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL clear_busy_no_output: got %0d valid cycles want 0", bad);
        end
        run_op(8'h80, 8'h80, 1'b0, s, lat);
        compared++;
        if (s !== 9'h100) begin
            mismatched++;
            $display("FAIL clear_busy_next_sum: got %h want 100", s);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q[$];
        int acc[$];
        logic [8:0] e;
        int got;
        int sent;
        logic took;
        got = 0;
        sent = 0;
        ror[0] = 1'b1;
        ra[0] = 16'h00C3;
        rb[0] = 16'h0071;
        rci[0] = 1'b1;
        rv[0] = 1'b1;
        for (int t = 0; t < 200 && got < 4; t++) begin
            took = 1'b0;
            if (rv[0] && irdy[0]) begin
                q.push_back({1'b0, ra[0][7:0]} + {1'b0, rb[0][7:0]} + {8'd0, rci[0]});
                acc.push_back(cyc);
                sent++;
                took = 1'b1;
            end
            if (ovld[0]) begin
                e = (q.size() > 0) ? q.pop_front() : 9'h1EE;
                compared++;
                if (s0 !== e) begin
                    mismatched++;
                    $display("FAIL b2b_sum[%0d]: got %h want %h", got, s0, e);
                end
                got++;
            end
            @(negedge clk);
            if (took) begin
                ra[0] = {8'd0, 8'($urandom)};
                rb[0] = {8'd0, 8'($urandom)};
                rci[0] = 1'($urandom);
                if (sent == 4) rv[0] = 1'b0;
            end
        end
        rv[0] = 1'b0;
        compared++;
        if (got !== 4) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d results want 4", got);
        end
        for (int i = 1; i < acc.size(); i++) begin
            compared++;
            if (acc[i] - acc[i-1] !== 10) begin
                mismatched++;
                $display("FAIL b2b_interval[%0d]: got %0d want 10", i, acc[i] - acc[i-1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int k, input int count);
        logic [16:0] q[$];
        logic [16:0] e;
        logic [15:0] mask;
        int got;
        int sent;
        int t;
        logic took;
        mask = 16'((32'd1 << wid(k)) - 1);
        got = 0;
        sent = 0;
        t = 0;
        rv[k] = 1'b0;
        while (got < count && t < 40000) begin
            if (!rv[k] && sent < count && $urandom_range(0, 3) != 0) begin
                ra[k] = 16'($urandom) & mask;
                rb[k] = 16'($urandom) & mask;
                rci[k] = 1'($urandom);
                rv[k] = 1'b1;
            end
            took = 1'b0;
            if (rv[k] && irdy[k]) begin
                q.push_back({1'b0, ra[k]} + {1'b0, rb[k]} + {16'd0, rci[k]});
                sent++;
                took = 1'b1;
            end
            ror[k] = ($urandom_range(0, 3) != 0);
            if (ovld[k] && ror[k]) begin
                e = (q.size() > 0) ? q.pop_front() : 17'h1DEAD;
                compared++;
                if (getsum(k) !== e) begin
                    mismatched++;
                    $display("FAIL rand_n%0d[%0d]: got %h want %h", wid(k), got, getsum(k), e);
                end
                got++;
            end
            @(negedge clk);
            t++;
            if (took) rv[k] = 1'b0;
        end
        rv[k] = 1'b0;
        ror[k] = 1'b1;
        compared++;
        if (got !== count) begin
            mismatched++;
            $display("FAIL rand_n%0d_count: got %0d results want %0d", wid(k), got, count);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0;
            ror[k] = 1'b1;
            rci[k] = 1'b0;
            ra[k] = '0;
            rb[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_clear_busy();
        test_back_to_back();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
